// File: rtl/tx_framer_if.sv
// rtl/tx_framer_if.sv - RAM read port and modulator bit stream between the framer and its neighbours
interface tx_framer_if;
  logic       o_ram_rd;
  logic [9:0] o_ram_addr;
  logic [7:0] i_ram_data;
  logic       i_bit_tick;
  logic       o_bit;
  logic       o_tx_en;

  modport master (
    output o_ram_rd, o_ram_addr, o_bit, o_tx_en,
    input  i_ram_data, i_bit_tick
  );

  modport slave (
    input  o_ram_rd, o_ram_addr, o_bit, o_tx_en,
    output i_ram_data, i_bit_tick
  );
endinterface

// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - serialises preamble, sync word, length and RAM payload to the modulator; CW test mode
module tx_framer #(
  parameter int          PREAMBLE_BYTES = 4,
  parameter logic [15:0] SYNC_WORD      = 16'hD391,
  parameter int          MAX_LEN        = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_transmit,
  input  logic [9:0]        i_msg_length,
  input  logic              i_cw,
  output logic              o_tx_done,
  tx_framer_if.master       bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CW     = 3'd1;
  localparam logic [2:0] S_PRE    = 3'd2;
  localparam logic [2:0] S_SYNC   = 3'd3;
  localparam logic [2:0] S_LEN_HI = 3'd4;
  localparam logic [2:0] S_LEN_LO = 3'd5;
  localparam logic [2:0] S_PAY    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [9:0] MAX_LEN_V = 10'(MAX_LEN);
  localparam logic [9:0] PRE_LAST  = 10'(PREAMBLE_BYTES - 1);

  logic [2:0] state;
  logic       trans_q;
  logic [9:0] len;
  logic [9:0] byte_cnt;
  logic [9:0] fetch_addr;
  logic [9:0] ram_addr_q;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] prefetch;
  logic       fetch_pend;
  logic       rd_q;
  logic       cap_q;
  logic       cw_done_q;

  logic       tx_rise;
  logic       in_frame;
  logic       boundary;
  logic [9:0] len_clamped;
  logic [9:0] len_m1;
  logic [9:0] byte_next;

  assign tx_rise     = i_transmit & ~trans_q;
  assign in_frame    = (state == S_PRE) || (state == S_SYNC) || (state == S_LEN_HI) ||
                       (state == S_LEN_LO) || (state == S_PAY);
  assign boundary    = in_frame && bus.i_bit_tick && (bit_cnt == 3'd7);
  assign len_clamped = (i_msg_length > MAX_LEN_V) ? MAX_LEN_V : i_msg_length;
  assign len_m1      = len - 10'd1;
  assign byte_next   = byte_cnt + 10'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      trans_q    <= 1'b1;
      len        <= '0;
      byte_cnt   <= '0;
      fetch_addr <= '0;
      ram_addr_q <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      prefetch   <= '0;
      fetch_pend <= 1'b0;
      rd_q       <= 1'b0;
      cap_q      <= 1'b0;
      cw_done_q  <= 1'b0;
    end else begin
      trans_q    <= i_transmit;
      cw_done_q  <= tx_rise && ((state == S_IDLE && i_cw) || state == S_CW);
      rd_q       <= fetch_pend;
      cap_q      <= rd_q;
      fetch_pend <= 1'b0;

      // Fetch runs one clk behind the strobe so the RAM sees a stable address.
      if (fetch_pend) begin
        ram_addr_q <= fetch_addr;
        fetch_addr <= fetch_addr + 10'd1;
      end
      if (cap_q) prefetch <= bus.i_ram_data;

      if (in_frame && bus.i_bit_tick) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (!boundary) shreg <= {shreg[6:0], 1'b0};
      end

      case (state)
        S_IDLE: begin
          if (i_cw) begin
            state <= S_CW;
          end else if (tx_rise) begin
            state      <= S_PRE;
            len        <= len_clamped;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            fetch_addr <= '0;
            shreg      <= 8'hAA;
          end
        end
        S_CW: begin
          if (!i_cw) state <= S_IDLE;
        end
        S_PRE: begin
          if (boundary) begin
            if (byte_cnt == PRE_LAST) begin
              state    <= S_SYNC;
              shreg    <= SYNC_WORD[15:8];
              byte_cnt <= '0;
            end else begin
              shreg    <= 8'hAA;
              byte_cnt <= byte_next;
            end
          end
        end
        S_SYNC: begin
          if (boundary) begin
            if (byte_cnt == 10'd0) begin
              shreg    <= SYNC_WORD[7:0];
              byte_cnt <= 10'd1;
            end else begin
              state <= S_LEN_HI;
              shreg <= {6'b0, len[9:8]};
            end
          end
        end
        S_LEN_HI: begin
          if (boundary) begin
            state      <= S_LEN_LO;
            shreg      <= len[7:0];
            fetch_pend <= (len != 10'd0);
          end
        end
        S_LEN_LO: begin
          if (boundary) begin
            if (len == 10'd0) begin
              state <= S_DONE;
            end else begin
              state      <= S_PAY;
              shreg      <= prefetch;
              byte_cnt   <= '0;
              fetch_pend <= (len_m1 != 10'd0);
            end
          end
        end
        S_PAY: begin
          if (boundary) begin
            if (byte_cnt == len_m1) begin
              state <= S_DONE;
            end else begin
              shreg      <= prefetch;
              byte_cnt   <= byte_next;
              fetch_pend <= (byte_next != len_m1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx_en    = (state == S_CW) || in_frame;
  assign bus.o_bit      = (state == S_CW) || (in_frame && shreg[7]);
  assign bus.o_ram_rd   = rd_q;
  assign bus.o_ram_addr = ram_addr_q;
  assign o_tx_done      = (state == S_DONE) || cw_done_q;

endmodule

// File: doc/tx_framer.md
# tx_framer

Transmit framer between the register/SPI control block and the modulator. It detects a rising edge on the control block's transmit flag and reads the staged payload out of the shared message RAM. It serialises a complete frame (preamble, sync word, length, payload) one bit per modulator bit tick, then pulses tx_done so the control block clears its transmit flag. It also gates the PA enable and provides the unmodulated-carrier (CW) test mode.

## Interface
Parameters:
- PREAMBLE_BYTES, 4: number of 0xAA preamble bytes, valid range 1..15.
- SYNC_WORD, 16'hD391: sync word, sent MSB first.
- MAX_LEN, 1000: RAM payload capacity in bytes; longer lengths are clamped to this.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_transmit  in  1  transmit flag from the control block (level).
- i_msg_length  in  10  payload length in bytes; sampled at frame start.
- i_cw  in  1  CW test-mode request (level).
- i_ram_data  in  8  RAM read data; valid 1 clk after o_ram_rd.
- o_ram_rd  out  1  RAM read strobe, one clk wide.
- o_ram_addr  out  10  RAM read address.
- i_bit_tick  in  1  one-clk pulse per bit period from the modulator; ticks are at least 3 clk apart.
- o_bit  out  1  current line bit to the modulator.
- o_tx_en  out  1  PA/modulator enable.
- o_tx_done  out  1  one-clk pulse at frame end.

## Operation
- Reset values: all outputs 0; state IDLE; stored transmit-edge history = 1, so a flag that is already high at reset release does not start a frame.
- Start condition: the frame starts on a rising edge of i_transmit, never on its level. The control flag stays high for about 2 clk after o_tx_done and must not retrigger a frame.
- States: IDLE, CW, PREAMBLE, SYNC, LEN_HI, LEN_LO, PAYLOAD, DONE.
- IDLE:
  - i_cw=1 → CW.
  - Otherwise, a transmit rising edge → PREAMBLE.
  - If both occur in the same clk, CW wins and the edge is handled as in CW.
- CW:
  - o_tx_en=1, o_bit=1, no RAM reads.
  - A transmit rising edge while in CW discards the frame and pulses o_tx_done.
  - i_cw=0 → IDLE next clk.
- Frame content, every field MSB first:
  - PREAMBLE_BYTES × 0xAA.
  - SYNC_WORD.
  - Length high byte {6'b0, L[9:8]}.
  - Length low byte L[7:0].
  - L payload bytes from RAM addresses 0..L-1.
- Length rule: L = min(i_msg_length, MAX_LEN), latched at frame start. Later changes to i_msg_length are ignored.
- L=0: no PAYLOAD state and no RAM reads; LEN_LO → DONE.
- Payload fetch:
  - Read address k is issued (o_ram_rd pulse) on the clk after bit 0 of the preceding byte is presented: the LEN_LO byte for k=0, payload byte k-1 for k≥1.
  - Data is captured into a prefetch register the following clk, well before the byte boundary tick.
  - An 8-bit shift register reloads from the prefetch register at each byte boundary.
- DONE: o_tx_en=0, o_tx_done=1 for exactly one clk, then IDLE.
- i_cw asserted mid-frame is ignored until the frame ends.
- Bit counter: 3 bits with wrap 7→0 at each byte boundary. Byte counter: 10 bits compared against L-1.

## Timing
- Transmit edge sampled at clk T:
  - T+1: state PREAMBLE, o_tx_en=1, o_bit = first preamble bit (1).
  - T+2: o_ram_rd for address 0 only when PREAMBLE is the byte before the first fetch; in general the fetch rule above applies.
- Each i_bit_tick at clk t: o_bit shows the next bit at t+1. Bit n is presented after tick n-1.
- Total frame bits N = 8·PREAMBLE_BYTES + 32 + 8·L.
- The Nth tick at clk t gives: state DONE and o_tx_done=1 at t+1, o_tx_en=0 at t+1, o_bit=0 at t+1.
- A tick arriving the same clk as the transmit edge is ignored; the first bit always lasts one full bit period.
- Reset mid-frame: all outputs are 0 the next clk, no o_tx_done pulse, no RAM read. Transmit-edge history is set to 1, as at reset.
- Worst-case RAM path: address to data is 1 clk; the fetch completes at least 5 clk before it is needed.

## Test plan
- PREAMBLE_BYTES=4, RAM[0]=0x3C, RAM[1]=0xC3, i_msg_length=2, ticks every 4 clk:
  - 80 ticks give bits AA AA AA AA D3 91 00 02 3C C3, MSB first.
  - o_tx_done pulses once, 1 clk after tick 80.
  - o_tx_en high for the whole frame.
- i_msg_length=0:
  - 64 bits ending with 00 00.
  - Zero o_ram_rd pulses, then o_tx_done.
- i_msg_length=1023:
  - Length bytes read 03 E8.
  - Exactly 1000 reads with addresses 0..999, no address ≥1000.
- Transmit held high for 3 clk after o_tx_done, then a new rising edge:
  - Exactly one new frame.
  - No frame while the flag stays high; no frame if the flag is high at reset release.
- i_cw=1 in IDLE:
  - o_tx_en=1, o_bit=1 constant.
  - A transmit edge gives one o_tx_done with no RAM reads.
  - i_cw=0 gives o_tx_en=0 next clk.
- Reset asserted at tick 40 of a frame:
  - All outputs 0 next clk, no o_tx_done.
  - A later rising edge sends a complete, correct frame.
